// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch types: data-width aliases, fetch FSM states and the default boot address.
package fetch_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam u64 DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Head of the fetch stage: owns the architectural PC, issues one instruction-bus request at a time,
// buffers the returned word for decode and discards words made stale by a branch redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output u64          pc,
    output u64          pcplus4,
    input  u64          pc_selected,
    input  logic        branch_taken,
    output logic        req_valid,
    output u64          req_addr,
    input  logic        resp_data_ok,
    input  u32          resp_data,
    output logic        inst_valid,
    output u32          inst,
    output u64          inst_pc,
    input  logic        out_ready
);

    fetch_state_t state_reg;

    // Wraps modulo 2^64; pc[1:0] is carried through untouched.
    assign pcplus4 = pc + 64'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            req_valid  <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    req_valid <= 1'b1;
                    state_reg <= S_REQ;
                    if (branch_taken) begin
                        pc       <= pc_selected;
                        req_addr <= pc_selected;
                    end else begin
                        req_addr <= pc;
                    end
                end

                S_REQ: begin
                    if (resp_data_ok && !branch_taken) begin
                        inst       <= resp_data;
                        inst_pc    <= req_addr;
                        pc         <= pc_selected;
                        inst_valid <= 1'b1;
                        req_valid  <= 1'b0;
                        state_reg  <= S_HOLD;
                    end else if (resp_data_ok) begin
                        // Word arrived together with a redirect: drop it and reissue at the target.
                        pc       <= pc_selected;
                        req_addr <= pc_selected;
                    end else if (branch_taken) begin
                        // Bus request must stay stable, so ride it out in S_DROP.
                        pc        <= pc_selected;
                        state_reg <= S_DROP;
                    end
                end

                S_HOLD: begin
                    if (branch_taken) begin
                        inst_valid <= 1'b0;
                        pc         <= pc_selected;
                        req_addr   <= pc_selected;
                        req_valid  <= 1'b1;
                        state_reg  <= S_REQ;
                    end else if (out_ready) begin
                        inst_valid <= 1'b0;
                        req_addr   <= pc;
                        req_valid  <= 1'b1;
                        state_reg  <= S_REQ;
                    end
                end

                S_DROP: begin
                    if (branch_taken) begin
                        pc <= pc_selected;
                    end
                    if (resp_data_ok) begin
                        req_addr  <= branch_taken ? pc_selected : pc;
                        state_reg <= S_REQ;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    u64   pc, pcplus4, pc_selected, req_addr, inst_pc;
    u64   target = '0;
    logic branch_taken = 1'b0;
    logic req_valid, inst_valid;
    logic resp_data_ok = 1'b0;
    u32   resp_data = '0;
    u32   inst;
    logic out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    string phase = "reset";

    always #5 clk = ~clk;

    // Stand-in for pcselect: the redirect target wins, otherwise the sequential address.
    assign pc_selected = branch_taken ? target : pcplus4;

    fetch_ctrl #(.RESET_PC(64'h8000_0000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pcplus4(pcplus4), .pc_selected(pc_selected),
        .branch_taken(branch_taken), .req_valid(req_valid), .req_addr(req_addr),
        .resp_data_ok(resp_data_ok), .resp_data(resp_data), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .out_ready(out_ready)
    );

    // Reference model: a started flag, a stale-request flag and a one-deep queue of fetched words.
    typedef struct { u32 word; u64 addr; } fetched_t;
    fetched_t m_buf[$];
    bit m_started, m_stale;
    u64 m_pc, m_addr;

    task automatic model_reset();
        m_started = 0; m_stale = 0; m_buf.delete();
        m_pc = 64'h8000_0000; m_addr = 64'h8000_0000;
    endtask

    function automatic bit model_outstanding();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic model_step(input logic b, input u64 t, input logic d, input u32 w, input logic r);
        fetched_t f;
        if (!m_started) begin
            m_started = 1;
            if (b) begin m_pc = t; m_addr = t; end else m_addr = m_pc;
        end else if (m_buf.size() != 0) begin
            if (b || r) begin
                f = m_buf.pop_front();
                if (b) begin m_pc = t; m_addr = t; end else m_addr = m_pc;
            end
        end else if (d) begin
            if (m_stale) begin
                m_stale = 0;
                if (b) m_pc = t;
                m_addr = m_pc;
            end else if (b) begin
                m_pc = t; m_addr = t;
            end else begin
                f.word = w; f.addr = m_addr;
                m_buf.push_back(f);
                m_pc = m_pc + 64'd4;
            end
        end else if (b) begin
            m_pc = t; m_stale = 1;
        end
    endtask

    task automatic chk(input string tag, input u64 obs, input u64 exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("pcplus4", pcplus4, m_pc + 64'd4);
        chk("req_valid", {63'd0, req_valid}, {63'd0, model_outstanding()});
        chk("req_addr", req_addr, m_addr);
        chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_buf.size() != 0});
        if (m_buf.size() != 0) begin
            chk("inst", {32'd0, inst}, {32'd0, m_buf[0].word});
            chk("inst_pc", inst_pc, m_buf[0].addr);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_req_addr", req_addr, 64'h8000_0000);
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
    endtask

    // Drives one cycle of inputs, advances the model at the edge and compares just after it.
    task automatic step(input logic b, input u64 t, input logic d, input u32 w, input logic r);
        branch_taken = b; target = t; resp_data_ok = d; resp_data = w; out_ready = r;
        @(posedge clk);
        model_step(b, t, d, w, r);
        #1;
        check_model();
        $display("cycle %s bt=%0d tgt=%h ok=%0d rdy=%0d -> pc=%h req=%0d@%h iv=%0d inst=%h@%h",
                 phase, b, t, d, r, pc, req_valid, req_addr, inst_valid, inst, inst_pc);
    endtask

    initial begin
        logic b, d, r;
        u64 t;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_values();
        reset = 1'b0;

        phase = "t1_first_fetch";
        step(0, '0, 0, '0, 0);
        chk("req_addr0", req_addr, 64'h8000_0000);
        step(0, '0, 0, '0, 0);
        step(0, '0, 0, '0, 0);
        step(0, '0, 1, 32'h0000_0013, 0);
        chk("inst_pc0", inst_pc, 64'h8000_0000);
        chk("inst0", {32'd0, inst}, 64'h13);

        phase = "t2_hold";
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0, '0, 0);
            chk("hold_req_valid", {63'd0, req_valid}, 64'd0);
            chk("hold_pc", pc, 64'h8000_0004);
        end
        step(0, '0, 0, '0, 1);
        chk("req_addr1", req_addr, 64'h8000_0004);

        phase = "t3_drop";
        step(1, 64'h8000_0100, 0, '0, 0);
        chk("drop_addr_held", req_addr, 64'h8000_0004);
        step(0, '0, 0, '0, 0);
        step(0, '0, 1, 32'hDEAD_BEEF, 1);
        chk("drop_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("drop_next_addr", req_addr, 64'h8000_0100);

        phase = "t4_bt_with_ok";
        step(1, 64'h8000_0180, 1, 32'hCAFE_F00D, 0);
        chk("bt_ok_valid", {63'd0, req_valid}, 64'd1);
        chk("bt_ok_addr", req_addr, 64'h8000_0180);

        phase = "t5_double_redirect";
        step(1, 64'h8000_01C0, 0, '0, 0);
        step(1, 64'h8000_0200, 0, '0, 0);
        step(1, 64'h8000_0300, 0, '0, 0);
        step(0, '0, 1, 32'h1111_1111, 0);
        chk("newest_target", req_addr, 64'h8000_0300);

        phase = "t6_bt_in_hold";
        step(0, '0, 1, 32'h0050_0093, 0);
        step(1, 64'h8000_0400, 0, '0, 1);
        chk("restart_addr", req_addr, 64'h8000_0400);
        step(1, 64'h8000_0500, 0, '0, 0);
        reset = 1'b1;
        #1;
        phase = "t6_async_reset";
        check_reset_values();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        phase = "wrap";
        step(0, '0, 0, '0, 0);
        step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, '0, 0);
        step(0, '0, 1, 32'h2222_2222, 0);
        step(0, '0, 1, 32'h3333_3333, 0);
        chk("wrap_pc", pc, 64'h2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 5) == 0);
            t = {$urandom, $urandom};
            d = model_outstanding() && ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 1);
            step(b, t, d, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
